// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, issuer FSM states and the queued command record shared by the ALU command issuer
package alu_pkg;
  // Operand width of the queued command record; the issuer supports WIDTH up to this value
  localparam int ALU_W = 16;
  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_GT   = 3'd7;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
  typedef struct packed {
    logic [2:0]       op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             use_acc;
  } cmd_t;
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command and result valid/ready handshakes between a command source and the issuer
//   master: drives cmd_valid/cmd_op/cmd_a/cmd_b/cmd_use_acc and res_ready
//   slave : drives cmd_ready and res_valid/res_data/res_err
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_use_acc;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
    input  cmd_ready, res_valid, res_data, res_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, res_ready,
    output cmd_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with wrap-bit pointers
//   clk/rst      : clock, sync active-high reset (empties the FIFO)
//   push/din     : write request, ignored when full (full is the pre-pop state)
//   pop/dout     : read request, ignored when empty; dout shows the head
//   full/empty/count : occupancy
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_push, do_pop;
  assign count   = wp_q - rp_q;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rp_q[AW-1:0]];
  always_comb begin
    wp_d = do_push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop ? rp_q + 1'b1 : rp_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them to an external combinational ALU, returns results in order
//   clk/rst            : clock, sync active-high reset
//   io (slave)         : command handshake in, result handshake out (res_err flags divide by zero)
//   alu_in0/in1/sel    : registered operands/opcode to the ALU, held between commands
//   alu_out            : ALU result, captured one cycle after issue
//   busy               : commands queued or one in flight
//   Optional ALU_ACC_EN: accumulator of handshaked results, selectable as operand A via cmd_use_acc
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_issuer_if.slave  io,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);
  state_e state_q, state_d;
  cmd_t wr, head;
  logic full, empty, pop, hs, div0;
  logic [$clog2(DEPTH):0] count;
  logic [WIDTH-1:0] alu_in0_q, alu_in0_d, alu_in1_q, alu_in1_d, res_data_q, res_data_d, acc_now;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic res_valid_q, res_valid_d, res_err_q, res_err_d;
  assign wr = {io.cmd_op, ALU_W'(io.cmd_a), ALU_W'(io.cmd_b), io.cmd_use_acc};
  alu_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io.cmd_valid),
    .din   (wr),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign hs   = res_valid_q && io.res_ready;
  // res_valid is only ever high in RESP, so the handshake doubles as the RESP exit
  assign pop  = !empty && (state_q == IDLE || hs);
  assign div0 = alu_sel_q == OP_DIV && alu_in1_q == '0;
`ifdef ALU_ACC_EN
  localparam bit ACC_EN = 1'b1;
  logic [WIDTH-1:0] acc_q, acc_d;
  assign acc_d = hs ? res_data_q : acc_q;
  // a command popped on a handshake cycle sees the result being consumed
  assign acc_now = acc_d;
  always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
`else
  localparam bit ACC_EN = 1'b0;
  assign acc_now = '0;
`endif
  always_comb begin
    state_d     = state_q;
    alu_in0_d   = alu_in0_q;
    alu_in1_d   = alu_in1_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    if (state_q == ISSUE) state_d = CAPTURE;
    if (state_q == CAPTURE) begin
      state_d     = RESP;
      res_valid_d = 1'b1;
      res_data_d  = div0 ? '1 : alu_out;
      res_err_d   = div0;
    end
    if (hs) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
    end
    if (pop) begin
      state_d   = ISSUE;
      alu_in0_d = (ACC_EN && head.use_acc) ? acc_now : WIDTH'(head.a);
      alu_in1_d = WIDTH'(head.b);
      alu_sel_d = head.op;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_in0_q   <= '0;
      alu_in1_q   <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_in0_q   <= alu_in0_d;
      alu_in1_q   <= alu_in1_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end
  assign io.cmd_ready = !full;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_err   = res_err_q;
  assign alu_in0      = alu_in0_q;
  assign alu_in1      = alu_in1_q;
  assign alu_sel      = alu_sel_q;
  assign busy         = count != '0 || state_q != IDLE;
endmodule
